i3c_bus_monitor: RTL and testbench

- Sits between the MCU top's I3C target pins (split scl/sda/sel_od_pp) and the bench's I3C controller drive.
- Resolves the wired bus and flags push-pull contention.
- Synchronises and glitch-filters the bus, decodes START / repeated START / STOP / 9-bit data frames, and queues them as events in a small valid/ready FIFO for a checker or scoreboard.

---
 rtl/i3c_bus_monitor_pkg.sv | 16 +
 rtl/i3c_bus_monitor_filter.sv | 29 ++
 rtl/i3c_bus_monitor.sv | 136 +++++++++++++
 tb/tb_i3c_bus_monitor.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/i3c_bus_monitor_pkg.sv
// i3c_bus_monitor_pkg: shared event types and default parameters for the I3C bus monitor
package i3c_bus_monitor_pkg;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_CYCLES_DEF = 3;
  localparam int FIFO_DEPTH_DEF  = 8;
  typedef enum logic [1:0] {EVT_START, EVT_RSTART, EVT_STOP, EVT_DATA} evt_type_e;
  typedef enum logic {IDLE, FRAME} state_e;
  typedef struct packed {
    evt_type_e   typ;
    logic [7:0]  data;
    logic        bit9;
`ifdef I3C_BUS_MON_TIMESTAMP_EN
    logic [15:0] ts;
`endif
  } evt_t;
endpackage

// File: rtl/i3c_bus_monitor_filter.sv
// i3c_bus_monitor_filter: synchroniser plus consecutive-sample glitch filter for one bus line
module i3c_bus_monitor_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3
) (
  input  logic core_clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(FILT_CYCLES + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  // shift the raw line in, then toggle the output once the new level has persisted long enough
  always_ff @(posedge core_clk) begin
    if (rst) begin
      sync <= '1;
      cnt  <= '0;
      dout <= 1'b1;
    end else begin
      sync <= SYNC_STAGES'({sync, din});
      if (sync[SYNC_STAGES-1] == dout) cnt <= '0;
      else if (cnt == CW'(FILT_CYCLES - 1)) begin
        dout <= ~dout;
        cnt  <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/i3c_bus_monitor.sv
// i3c_bus_monitor: resolves the I3C bus, decodes START/RSTART/STOP/DATA into an event FIFO (optional timestamps via I3C_BUS_MON_TIMESTAMP_EN)
module i3c_bus_monitor
  import i3c_bus_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_CYCLES = FILT_CYCLES_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic        core_clk,
  input  logic        rst,
  input  logic        scl_o,
  input  logic        sda_o,
  input  logic        sel_od_pp_o,
  input  logic        ctrl_scl_o,
  input  logic        ctrl_sda_o,
  output logic        scl_bus,
  output logic        sda_bus,
  output logic        contention,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [1:0]  evt_type,
  output logic [7:0]  evt_data,
  output logic        evt_bit9,
  output logic        bus_busy,
  output logic        overflow,
`ifdef I3C_BUS_MON_TIMESTAMP_EN
  output logic [15:0] evt_ts,
`endif
  input  logic        clr_sticky
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic scl_f, sda_f, scl_q, sda_q;
  logic start_c, stop_c, scl_rise;
  state_e state;
  logic [3:0] bcnt;
  logic [7:0] shreg;
  logic push;
  evt_t push_evt, head;
  evt_t mem [FIFO_DEPTH];
  logic [AW:0] wr, rd;
  logic empty, full, pop, do_wr;
  assign scl_bus = ctrl_scl_o & scl_o;
  assign sda_bus = ctrl_sda_o & sda_o;
  i3c_bus_monitor_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_scl (
    .core_clk(core_clk), .rst(rst), .din(scl_bus), .dout(scl_f));
  i3c_bus_monitor_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_sda (
    .core_clk(core_clk), .rst(rst), .din(sda_bus), .dout(sda_f));
  // an SDA edge only counts as START/STOP while SCL is steadily high, so a simultaneous SCL edge wins
  assign scl_rise = scl_f & ~scl_q;
  assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;
`ifdef I3C_BUS_MON_TIMESTAMP_EN
  logic [15:0] ts_cnt;
  // free-running timestamp base
  always_ff @(posedge core_clk) ts_cnt <= rst ? 16'd0 : ts_cnt + 16'd1;
  assign evt_ts = head.ts;
`endif
  // decode FSM: tracks frame state and registers one event per detected condition
  always_ff @(posedge core_clk) begin
    if (rst) begin
      state    <= IDLE;
      bcnt     <= '0;
      shreg    <= '0;
      push     <= 1'b0;
      push_evt <= '0;
      bus_busy <= 1'b0;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
      push  <= 1'b0;
`ifdef I3C_BUS_MON_TIMESTAMP_EN
      push_evt.ts <= ts_cnt;
`endif
      if (scl_rise && state == FRAME) begin
        if (bcnt == 4'd8) begin
          push          <= 1'b1;
          push_evt.typ  <= EVT_DATA;
          push_evt.data <= shreg;
          push_evt.bit9 <= sda_f;
          bcnt          <= '0;
        end else begin
          shreg <= {shreg[6:0], sda_f};
          bcnt  <= bcnt + 4'd1;
        end
      end else if (start_c) begin
        push          <= 1'b1;
        push_evt.typ  <= state == IDLE ? EVT_START : EVT_RSTART;
        push_evt.data <= '0;
        push_evt.bit9 <= 1'b0;
        state         <= FRAME;
        bus_busy      <= 1'b1;
        bcnt          <= '0;
      end else if (stop_c && state == FRAME) begin
        push          <= 1'b1;
        push_evt.typ  <= EVT_STOP;
        push_evt.data <= '0;
        push_evt.bit9 <= 1'b0;
        state         <= IDLE;
        bus_busy      <= 1'b0;
      end
    end
  end
  assign empty  = wr == rd;
  assign full   = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign pop    = evt_ready & ~empty;
  assign do_wr  = push & (~full | pop);
  assign head   = empty ? '0 : mem[rd[AW-1:0]];
  assign evt_valid = ~empty;
  assign evt_type  = head.typ;
  assign evt_data  = head.data;
  assign evt_bit9  = head.bit9;
  // FIFO storage
  always_ff @(posedge core_clk) if (do_wr) mem[wr[AW-1:0]] <= push_evt;
  // FIFO pointers with an extra wrap bit to tell full from empty
  always_ff @(posedge core_clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (do_wr) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
    end
  end
  // sticky flags; a clear beats a same-cycle set
  always_ff @(posedge core_clk) begin
    if (rst || clr_sticky) begin
      overflow   <= 1'b0;
      contention <= 1'b0;
    end else begin
      if (push && full && !pop) overflow <= 1'b1;
      if (sel_od_pp_o && sda_o && !ctrl_sda_o && !scl_f) contention <= 1'b1;
    end
  end
endmodule

// File: tb/tb_i3c_bus_monitor.sv
// tb_i3c_bus_monitor: table-driven and scoreboard bench for the I3C bus monitor
module tb_i3c_bus_monitor;
  logic core_clk = 0, rst, scl_o, sda_o, sel, ctrl_scl, ctrl_sda, rdy, clr;
  logic scl_bus, sda_bus, contention, evt_valid, evt_bit9, bus_busy, overflow;
  logic [1:0] evt_type;
  logic [7:0] evt_data;
`ifdef I3C_BUS_MON_TIMESTAMP_EN
  logic [15:0] evt_ts, t0;
`endif
  int checks = 0, fails = 0;
  logic [10:0] q[$];
  typedef struct {logic cs, so, cd, do_, es, ed;} vec_t;
  typedef struct {logic rs; logic [7:0] d; logic b9;} frm_t;
  vec_t vecs[4];
  frm_t frms[3];
  always #5 core_clk = ~core_clk;
  i3c_bus_monitor dut (
    .core_clk(core_clk), .rst(rst), .scl_o(scl_o), .sda_o(sda_o), .sel_od_pp_o(sel),
    .ctrl_scl_o(ctrl_scl), .ctrl_sda_o(ctrl_sda), .scl_bus(scl_bus), .sda_bus(sda_bus),
    .contention(contention), .evt_valid(evt_valid), .evt_ready(rdy), .evt_type(evt_type),
    .evt_data(evt_data), .evt_bit9(evt_bit9), .bus_busy(bus_busy), .overflow(overflow),
`ifdef I3C_BUS_MON_TIMESTAMP_EN
    .evt_ts(evt_ts),
`endif
    .clr_sticky(clr));
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask
  // scoreboard: every event the consumer accepts must match the oldest expectation
  always @(negedge core_clk) begin
    if (!rst && evt_valid && rdy) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event got=%h", {evt_type, evt_data, evt_bit9});
      end else begin
        logic [10:0] e;
        e = q.pop_front();
        if ({evt_type, evt_data, evt_bit9} !== e) begin
          fails++;
          $display("FAIL event got=%h exp=%h", {evt_type, evt_data, evt_bit9}, e);
        end
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge core_clk);
    #1;
  endtask
  task automatic exp_evt(input logic [1:0] t, input logic [7:0] d, input logic b);
    q.push_back({t, d, b});
  endtask
  task automatic start_cond;
    ctrl_sda = 1; cyc(8); ctrl_scl = 1; cyc(8); ctrl_sda = 0; cyc(8); ctrl_scl = 0; cyc(4);
  endtask
  task automatic stop_cond;
    ctrl_sda = 0; cyc(8); ctrl_scl = 1; cyc(8); ctrl_sda = 1; cyc(8);
  endtask
  task automatic send_bit(input logic b);
    ctrl_sda = b; cyc(4); ctrl_scl = 1; cyc(8); ctrl_scl = 0; cyc(4);
  endtask
  task automatic send_byte(input logic [7:0] d, input logic b9);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(b9);
  endtask
  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 400) begin cyc(1); n++; end
    chk("drain_left", 16'(q.size()), 16'd0);
    cyc(2);
    chk("drain_valid", {15'd0, evt_valid}, 16'd0);
  endtask
  initial begin
    vecs[0] = '{1, 1, 1, 1, 1, 1};
    vecs[1] = '{0, 1, 1, 0, 0, 0};
    vecs[2] = '{1, 0, 0, 1, 0, 0};
    vecs[3] = '{0, 0, 0, 0, 0, 0};
    frms[0] = '{0, 8'hA5, 0};
    frms[1] = '{1, 8'h3C, 1};
    frms[2] = '{0, 8'h5A, 1};
    rst = 1; rdy = 1; clr = 0; ctrl_scl = 1; ctrl_sda = 1; scl_o = 1; sda_o = 1; sel = 0;
    cyc(2);
    foreach (vecs[i]) begin
      ctrl_scl = vecs[i].cs; scl_o = vecs[i].so; ctrl_sda = vecs[i].cd; sda_o = vecs[i].do_;
      #1;
      chk("scl_bus", {15'd0, scl_bus}, {15'd0, vecs[i].es});
      chk("sda_bus", {15'd0, sda_bus}, {15'd0, vecs[i].ed});
    end
    ctrl_scl = 1; scl_o = 1; ctrl_sda = 1; sda_o = 1;
    cyc(10);
    chk("rst_valid", {15'd0, evt_valid}, 16'd0);
    chk("rst_busy", {15'd0, bus_busy}, 16'd0);
    chk("rst_ovf", {15'd0, overflow}, 16'd0);
    chk("rst_cont", {15'd0, contention}, 16'd0);
    chk("rst_head", {5'd0, evt_type, evt_data, evt_bit9}, 16'd0);
    rst = 0;
    cyc(10);
    foreach (frms[i]) begin
      exp_evt(2'd0, 8'h00, 0);
      start_cond();
      chk("busy_in_frame", {15'd0, bus_busy}, 16'd1);
      if (frms[i].rs) begin
        for (int b = 0; b < 4; b++) send_bit(b[0]);
        exp_evt(2'd1, 8'h00, 0);
        start_cond();
      end
      exp_evt(2'd3, frms[i].d, frms[i].b9);
      send_byte(frms[i].d, frms[i].b9);
      exp_evt(2'd2, 8'h00, 0);
      stop_cond();
      cyc(4);
      chk("busy_after_stop", {15'd0, bus_busy}, 16'd0);
    end
    drain();
    ctrl_sda = 0; cyc(2); ctrl_sda = 1; cyc(20);
    chk("glitch2_valid", {15'd0, evt_valid}, 16'd0);
    chk("glitch2_busy", {15'd0, bus_busy}, 16'd0);
    exp_evt(2'd0, 8'h00, 0);
    exp_evt(2'd2, 8'h00, 0);
    ctrl_sda = 0; cyc(4); ctrl_sda = 1; cyc(20);
    drain();
    rdy = 0;
    for (int i = 0; i < 10; i++) begin
      ctrl_sda = i[0]; cyc(12);
      if (i < 8) exp_evt(i[0] ? 2'd2 : 2'd0, 8'h00, 0);
    end
    cyc(10);
    chk("ovf_set", {15'd0, overflow}, 16'd1);
    chk("full_valid", {15'd0, evt_valid}, 16'd1);
    clr = 1; cyc(1); clr = 0;
    chk("ovf_clr", {15'd0, overflow}, 16'd0);
    rdy = 1;
    drain();
    ctrl_scl = 0; cyc(10);
    sel = 1; sda_o = 1; ctrl_sda = 0; cyc(3);
    chk("sda_bus_cont", {15'd0, sda_bus}, 16'd0);
    chk("cont_set", {15'd0, contention}, 16'd1);
    clr = 1; cyc(1);
    chk("cont_clr_prio", {15'd0, contention}, 16'd0);
    clr = 0; cyc(1);
    chk("cont_reset", {15'd0, contention}, 16'd1);
    sel = 0; ctrl_sda = 1; cyc(10); ctrl_scl = 1; cyc(10);
    clr = 1; cyc(1); clr = 0; cyc(2);
    chk("cont_cleared", {15'd0, contention}, 16'd0);
    chk("idle_valid", {15'd0, evt_valid}, 16'd0);
`ifdef I3C_BUS_MON_TIMESTAMP_EN
    rdy = 0; rst = 1; cyc(2); rst = 0;
    cyc(100); ctrl_sda = 0; cyc(300); ctrl_sda = 1; cyc(20);
    exp_evt(2'd0, 8'h00, 0);
    exp_evt(2'd2, 8'h00, 0);
    t0 = evt_ts;
    rdy = 1; cyc(1); rdy = 0;
    chk("ts_delta", evt_ts - t0, 16'd300);
    rdy = 1;
    drain();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
